bram_video_reader: RTL and testbench
====================================

Name: bram_video_reader

Overview:
Reads the 24-bit frame buffer that the HDMI-input path writes and regenerates a standard DVI/VGA pixel stream from it: active-video enable, sync signals and RGB data. It is the reader/transmitter counterpart of the HDMI capture writer. It scans the stored IMG_W x IMG_H image, upscales it by integer pixel replication to the output raster, and drives bramaddr24b to the BRAM read port. The output feeds an rgb2dvi encoder.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of o_HSync
VS_POL, 0, asserted level of o_VSync
SCALE, 2, replication factor; IMG_W=H_ACTIVE/SCALE, IMG_H=V_ACTIVE/SCALE
RD_LAT, 1, BRAM read latency in cycles (1 or 2)

Ports:
pclk  in  1  pixel clock
aRst  in  1  asynchronous reset, active-high
i_en  in  1  run request; sampled at frame boundaries only
bram_dout  in  24  BRAM read data {R,G,B}, valid RD_LAT cycles after address
bramaddr24b  out  24  BRAM read address (registered)
o_rd_en  out  1  BRAM read enable; high only for active-region reads
o_HSync  out  1  horizontal sync
o_VSync  out  1  vertical sync
o_VDE  out  1  active-video enable
rgb_r, rgb_g, rgb_b  out  8 each  pixel data; forced to 0 when o_VDE=0
o_frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async, immediate): state IDLE; h_cnt=v_cnt=0; bramaddr24b=0; o_rd_en=0; o_VDE=0; rgb=0; o_HSync=~HS_POL; o_VSync=~VS_POL; o_frame_start=0; pipeline registers cleared.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- FSM IDLE: counters held at 0, outputs at reset values. i_en=1 -> RUN on the next cycle, starting at h=0, v=0.
- FSM RUN: h_cnt increments each cycle and wraps at H_TOTAL-1, incrementing v_cnt; v_cnt wraps at V_TOTAL-1. At h=H_TOTAL-1, v=V_TOTAL-1: i_en=1 -> wrap to frame 0; i_en=0 -> IDLE. A drop of i_en mid-frame never truncates the frame.
- Active region: h<H_ACTIVE and v<V_ACTIVE. Hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Vsync asserted for lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, across the whole line.
- Address generation uses incremental counters, no multiplier. A column sub-counter advances the address every SCALE active pixels. At line end the address returns to line_base. line_base advances by IMG_W every SCALE lines and resets to 0 at frame start.
- The address for pixel (h,v) is floor(v/SCALE)*IMG_W + floor(h/SCALE). The last active pixel reads IMG_W*IMG_H-1 (76799).
- Pipeline: bramaddr24b and o_rd_en are registered 1 cycle after the counters. bram_dout is captured into the rgb registers RD_LAT cycles later. o_HSync, o_VSync, o_VDE and o_frame_start are delayed by the same amount, giving RD_LAT+2 cycles from counter to output pins. All outputs are mutually aligned.
- o_rd_en=0 in blanking. bramaddr24b holds its last value in blanking.

Decomposition:
- Package: video timing constants (640x480@60 set), H_TOTAL/V_TOTAL functions, counter width constants, {R,G,B} slice constants.
- One sub-module: video_timing_gen (h/v counters, run/idle FSM, raw hs/vs/de, frame-start flag).
- Address generation and the alignment pipeline live in the top.

Test Plan:
1. Assert aRst mid-frame with i_en=1 -> all outputs return to their reset values within the same cycle (syncs=1, VDE=0, addr=0, rgb=0).
2. i_en=1 with a BRAM model returning data=addr -> line 0 reads addresses 0,0,1,1,...,319,319. Line 1 repeats this. Line 2 starts at 320. The last active pixel reads 76799.
3. Sync check -> o_HSync low for 96 cycles, falling 656 cycles after VDE rises. o_VSync low for exactly 2x800 cycles. o_frame_start period is exactly 420000 cycles.
4. Alignment with RD_LAT=1 and RD_LAT=2 -> at each VDE rising edge rgb equals the word at the line-base address. rgb=0 whenever VDE=0.
5. Deassert i_en mid-frame -> the frame completes (VDE count 307200), then IDLE with no further frame_start pulses. Reassert -> the next frame starts with address 0.
6. i_en held high across frames -> counters wrap with no gap cycle. The second frame's first pixel reads address 0.

Source files
------------

// File: rtl/bram_video_reader_pkg.sv
// Shared timing constants, widths and types for the BRAM-backed DVI/VGA reader.
// Defaults describe the 640x480@60 raster.
package bram_video_reader_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CNT_W  = 12;
    localparam int ADDR_W = 24;
    localparam int PIX_W  = 24;

    // {R,G,B} layout of a frame-buffer word
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic {ST_IDLE, ST_RUN} vt_state_e;

    // Control bits carried down the alignment pipeline; hs/vs hold pin levels
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vid_ctl_t;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/bram_video_reader_timing.sv
// Raster counters with a run/idle FSM; a started frame always runs to completion.
// Decoded hs/vs/de/fs are active-high and forced low while idle.
module video_timing_gen
    import bram_video_reader_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             run_o,
    output logic             de_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             fs_o
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    vt_state_e        state_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (en_i) state_q <= ST_RUN;
                ST_RUN: begin
                    if (h_q == H_LAST) begin
                        h_q <= '0;
                        if (v_q == V_LAST) begin
                            v_q <= '0;
                            // en is only honoured here, at the frame boundary
                            if (!en_i) state_q <= ST_IDLE;
                        end else begin
                            v_q <= v_q + 1'b1;
                        end
                    end else begin
                        h_q <= h_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign h_o   = h_q;
    assign v_o   = v_q;
    assign run_o = (state_q == ST_RUN);
    assign de_o  = run_o && (h_q < HA_C) && (v_q < VA_C);
    assign hs_o  = run_o && (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_o  = run_o && (v_q >= VS_BEG) && (v_q < VS_END);
    assign fs_o  = run_o && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/bram_video_reader.sv
// Scans the stored IMG_W x IMG_H frame buffer, upscales it by pixel replication and
// emits an aligned DVI/VGA stream; address stage is 1 cycle, data stage RD_LAT+1 more.
module bram_video_reader
    import bram_video_reader_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int SCALE    = 2,
    parameter int RD_LAT   = 1
) (
    input  logic              pclk,
    input  logic              aRst,
    input  logic              i_en,
    input  logic [PIX_W-1:0]  bram_dout,
    output logic [ADDR_W-1:0] bramaddr24b,
    output logic              o_rd_en,
    output logic              o_HSync,
    output logic              o_VSync,
    output logic              o_VDE,
    output logic [7:0]        rgb_r,
    output logic [7:0]        rgb_g,
    output logic [7:0]        rgb_b,
    output logic              o_frame_start
);
    localparam int SC_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SC_W-1:0]   SC_LAST    = SC_W'(SCALE - 1);
    localparam logic [ADDR_W-1:0] IMG_W_C    = ADDR_W'(H_ACTIVE / SCALE);
    localparam logic [CNT_W-1:0]  H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  VA_C       = CNT_W'(V_ACTIVE);
    localparam vid_ctl_t CTL_RST = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0, fs: 1'b0};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic run, de_raw, hs_raw, vs_raw, fs_raw;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i(pclk), .rst_i(aRst), .en_i(i_en),
        .h_o(h_cnt), .v_o(v_cnt), .run_o(run),
        .de_o(de_raw), .hs_o(hs_raw), .vs_o(vs_raw), .fs_o(fs_raw)
    );

    logic [SC_W-1:0]   col_q, row_q;
    logic [ADDR_W-1:0] ptr_q, base_q, addr_q;
    logic              rd_en_q;

    // ptr_q is the address of the pixel under the counters; col/row count replicas
    always_ff @(posedge pclk or posedge aRst) begin
        if (aRst) begin
            col_q   <= '0;
            row_q   <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= de_raw;
            if (!run || v_cnt >= VA_C) begin
                col_q  <= '0;
                row_q  <= '0;
                ptr_q  <= '0;
                base_q <= '0;
            end else if (de_raw) begin
                addr_q <= ptr_q;
                if (h_cnt == H_LAST_ACT) begin
                    col_q <= '0;
                    if (row_q == SC_LAST) begin
                        row_q  <= '0;
                        base_q <= base_q + IMG_W_C;
                        ptr_q  <= base_q + IMG_W_C;
                    end else begin
                        row_q <= row_q + 1'b1;
                        ptr_q <= base_q;
                    end
                end else if (col_q == SC_LAST) begin
                    col_q <= '0;
                    ptr_q <= ptr_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    vid_ctl_t                ctl_raw;
    vid_ctl_t [RD_LAT+1:0]   pipe_q;
    logic     [PIX_W-1:0]    rgb_q;

    always_comb begin
        ctl_raw    = CTL_RST;
        ctl_raw.hs = hs_raw ? HS_POL : !HS_POL;
        ctl_raw.vs = vs_raw ? VS_POL : !VS_POL;
        ctl_raw.de = de_raw;
        ctl_raw.fs = fs_raw;
    end

    // Stage RD_LAT holds the control word matching the data now on bram_dout
    always_ff @(posedge pclk or posedge aRst) begin
        if (aRst) begin
            for (int i = 0; i <= RD_LAT + 1; i++) pipe_q[i] <= CTL_RST;
            rgb_q <= '0;
        end else begin
            pipe_q <= {pipe_q[RD_LAT:0], ctl_raw};
            rgb_q  <= pipe_q[RD_LAT].de ? bram_dout : '0;
        end
    end

    assign bramaddr24b   = addr_q;
    assign o_rd_en       = rd_en_q;
    assign o_HSync       = pipe_q[RD_LAT+1].hs;
    assign o_VSync       = pipe_q[RD_LAT+1].vs;
    assign o_VDE         = pipe_q[RD_LAT+1].de;
    assign o_frame_start = pipe_q[RD_LAT+1].fs;
    assign rgb_r         = rgb_q[R_MSB:R_LSB];
    assign rgb_g         = rgb_q[G_MSB:G_LSB];
    assign rgb_b         = rgb_q[B_MSB:B_LSB];

endmodule

// File: tb/tb_bram_video_reader.sv
// Directed bench on a shrunken 8x6 raster (15x10 total, SCALE 2 -> 4x3 image),
// one DUT per read latency, each fed by its own BRAM model returning 0x800000|addr.
module tb_bram_video_reader;
    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 15
    localparam int VT = VA + VFP + VSW + VBP;   // 10
    localparam int FR = HT * VT;                // 150

    logic pclk = 1'b0;
    logic aRst, i_en;
    logic [23:0] dout1, dout2, d2a, addr1, addr2;
    logic rd1, hs1, vs1, de1, fs1, rd2, hs2, vs2, de2, fs2;
    logic [7:0] r1, g1, b1, r2, g2, b2;

    int total = 0;
    int bad   = 0;
    int c_stop;
    logic [23:0] last_addr = '0;
    int vde_cnt, fs_cnt;
    int fs_k[$];
    logic [23:0] reads[$];

    always #5 pclk = ~pclk;

    bram_video_reader #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(2), .RD_LAT(1)) u1 (
        .pclk(pclk), .aRst(aRst), .i_en(i_en), .bram_dout(dout1),
        .bramaddr24b(addr1), .o_rd_en(rd1), .o_HSync(hs1), .o_VSync(vs1), .o_VDE(de1),
        .rgb_r(r1), .rgb_g(g1), .rgb_b(b1), .o_frame_start(fs1));

    bram_video_reader #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(2), .RD_LAT(2)) u2 (
        .pclk(pclk), .aRst(aRst), .i_en(i_en), .bram_dout(dout2),
        .bramaddr24b(addr2), .o_rd_en(rd2), .o_HSync(hs2), .o_VSync(vs2), .o_VDE(de2),
        .rgb_r(r2), .rgb_g(g2), .rgb_b(b2), .o_frame_start(fs2));

    function automatic logic [23:0] word(input logic [23:0] a);
        return 24'h800000 | a;
    endfunction

    initial begin dout1 = '0; dout2 = '0; d2a = '0; end
    always @(posedge pclk) begin
        if (rd1) dout1 <= word(addr1);
        if (rd2) d2a <= word(addr2);
        dout2 <= d2a;
    end

    // Raster model: c is the counter-cycle index since RUN was entered
    function automatic bit live(input int c);
        return (c >= 0) && (c <= c_stop);
    endfunction
    function automatic bit e_de(input int c);
        return live(c) && ((c % HT) < HA) && (((c / HT) % VT) < VA);
    endfunction
    function automatic bit e_hs(input int c);
        return !(live(c) && ((c % HT) >= HA + HFP) && ((c % HT) < HA + HFP + HSW));
    endfunction
    function automatic bit e_vs(input int c);
        return !(live(c) && (((c / HT) % VT) >= VA + VFP) && (((c / HT) % VT) < VA + VFP + VSW));
    endfunction
    function automatic bit e_fs(input int c);
        return live(c) && ((c % FR) == 0);
    endfunction
    function automatic logic [23:0] e_addr(input int c);
        return 24'(((((c / HT) % VT) / 2) * (HA / 2)) + ((c % HT) / 2));
    endfunction
    function automatic logic [23:0] e_rgb(input int c);
        return e_de(c) ? word(e_addr(c)) : 24'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string p, input int c, input logic hs, input logic vs,
                           input logic de, input logic fs, input logic [23:0] rgb);
        chk({p, "_hsync"}, 32'(hs), 32'(e_hs(c)));
        chk({p, "_vsync"}, 32'(vs), 32'(e_vs(c)));
        chk({p, "_vde"},   32'(de), 32'(e_de(c)));
        chk({p, "_fs"},    32'(fs), 32'(e_fs(c)));
        chk({p, "_rgb"},   32'(rgb), 32'(e_rgb(c)));
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_u1_hs"}, 32'(hs1), 1);  chk({p, "_u2_hs"}, 32'(hs2), 1);
        chk({p, "_u1_vs"}, 32'(vs1), 1);  chk({p, "_u2_vs"}, 32'(vs2), 1);
        chk({p, "_u1_de"}, 32'(de1), 0);  chk({p, "_u2_de"}, 32'(de2), 0);
        chk({p, "_u1_fs"}, 32'(fs1), 0);  chk({p, "_u2_fs"}, 32'(fs2), 0);
        chk({p, "_u1_rd"}, 32'(rd1), 0);  chk({p, "_u2_rd"}, 32'(rd2), 0);
        chk({p, "_u1_addr"}, 32'(addr1), 0); chk({p, "_u2_addr"}, 32'(addr2), 0);
        chk({p, "_u1_rgb"}, 32'({r1, g1, b1}), 0); chk({p, "_u2_rgb"}, 32'({r2, g2, b2}), 0);
    endtask

    // Entered #1 after an edge with i_en just raised; i_en drops after sample drop_k
    task automatic run_seg(input int ncyc, input int drop_k);
        c_stop  = (drop_k <= 0) ? 1000000000 : (((drop_k - 1) / FR) + 1) * FR - 1;
        vde_cnt = 0;
        fs_cnt  = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge pclk);
            #1;
            if (e_de(k - 2)) last_addr = e_addr(k - 2);
            chk("u1_rd_en", 32'(rd1), 32'(e_de(k - 2)));
            chk("u2_rd_en", 32'(rd2), 32'(e_de(k - 2)));
            chk("u1_addr", 32'(addr1), 32'(last_addr));
            chk("u2_addr", 32'(addr2), 32'(last_addr));
            chk_out("u1", k - 4, hs1, vs1, de1, fs1, {r1, g1, b1});
            chk_out("u2", k - 5, hs2, vs2, de2, fs2, {r2, g2, b2});
            if (de1) vde_cnt++;
            if (fs1) begin fs_cnt++; fs_k.push_back(k); end
            if (rd1 && reads.size() < 64) reads.push_back(addr1);
            if (k == drop_k) i_en = 1'b0;
        end
    endtask

    initial begin
        int l0[8];
        l0 = '{0, 0, 1, 1, 2, 2, 3, 3};
        aRst = 1'b1;
        i_en = 1'b0;
        #12;
        chk_reset("por");

        @(posedge pclk); #1;
        aRst = 1'b0;
        c_stop = -1;
        for (int k = 0; k < 5; k++) begin
            @(posedge pclk); #1;
            chk_out("idle_u1", -1, hs1, vs1, de1, fs1, {r1, g1, b1});
            chk("idle_u1_rd", 32'(rd1), 0);
        end

        // Two full frames back to back; i_en drops mid second frame
        i_en = 1'b1;
        run_seg(340, 200);
        chk("frames_vde_count", 32'(vde_cnt), 96);
        chk("frames_fs_count", 32'(fs_cnt), 2);
        chk("reads_captured", 32'(reads.size() >= 49), 1);
        if (fs_k.size() >= 2) begin
            chk("fs_first_k", 32'(fs_k[0]), 4);
            chk("fs_period", 32'(fs_k[1] - fs_k[0]), 150);
        end
        if (reads.size() >= 49) begin
            for (int i = 0; i < 8; i++) begin
                chk("line0_addr", 32'(reads[i]), 32'(l0[i]));
                chk("line1_addr", 32'(reads[i + 8]), 32'(l0[i]));
            end
            chk("line2_first", 32'(reads[16]), 4);
            chk("last_pixel", 32'(reads[47]), 11);
            chk("frame2_first", 32'(reads[48]), 0);
        end

        // Re-enable from IDLE, then reset in the middle of an active line
        i_en = 1'b1;
        run_seg(51, 0);
        chk("pre_reset_vde", 32'(de1), 1);
        #2;
        aRst = 1'b1;
        #1;
        chk_reset("midframe");
        @(negedge pclk);
        aRst = 1'b0;
        i_en = 1'b0;
        @(posedge pclk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
